instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end for a synchronous (one-cycle latency) memory.
// It issues one address per cycle and presents {pc, inst} over a valid/ready
// handshake. A one-entry skid buffer (hold) keeps a returned word safe while
// the consumer stalls. A redirect restarts the stream at a new target and
// drops any word that is held or still in flight.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   // Architectural state
   logic [31:0] fetch_pc_q,   fetch_pc_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_pc_q,    resp_pc_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_pc_q,    hold_pc_d;
   logic [31:0] hold_inst_q,  hold_inst_d;

   logic        issue;
   logic [31:0] redirect_tgt;
   logic        resp_stall;

   // Redirect targets are word aligned; the low two bits are ignored.
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};

   // A returned word that the consumer is refusing this cycle.
   assign resp_stall = resp_valid_q && !out_ready;

   // Issue a fetch unless the skid buffer is occupied or about to be filled.
   // A redirect always issues. Nothing issues while reset is asserted.
   assign issue = !rst && (redirect_valid || (!hold_valid_q && !resp_stall));

   // Memory address: a redirect is looked up in the same cycle it arrives.
   assign imem_addr = redirect_valid ? redirect_tgt : fetch_pc_q;

   // Presentation: the held word wins over the live memory response, and
   // nothing is offered in a redirect cycle because that word is stale.
   always_comb begin
      out_valid = (hold_valid_q || resp_valid_q) && !redirect_valid;
      if (hold_valid_q) begin
         out_pc   = hold_pc_q;
         out_inst = hold_inst_q;
      end else begin
         out_pc   = resp_pc_q;
         out_inst = imem_inst;
      end
   end

   // Next-state for the fetch pointer and the in-flight response tag.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      resp_valid_d = 1'b0;
      resp_pc_d    = resp_pc_q;
      if (issue) begin
         resp_valid_d = 1'b1;
         resp_pc_d    = imem_addr;
         fetch_pc_d   = imem_addr + 32'd4;   // wraps modulo 2^32
      end
   end

   // Next-state for the skid buffer: redirect flushes it, a handshake drains
   // it, and a stalled live response is captured before memory moves on.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_pc_d    = hold_pc_q;
      hold_inst_d  = hold_inst_q;
      if (redirect_valid) begin
         hold_valid_d = 1'b0;
      end else if (hold_valid_q) begin
         if (out_ready) hold_valid_d = 1'b0;
      end else if (resp_stall) begin
         hold_valid_d = 1'b1;
         hold_pc_d    = resp_pc_q;
         hold_inst_d  = imem_inst;
      end
   end

   // State registers with asynchronous reset to an empty pipeline at RESET_PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         resp_valid_q <= 1'b0;
         resp_pc_q    <= RESET_PC;
         hold_valid_q <= 1'b0;
         hold_pc_q    <= RESET_PC;
         hold_inst_q  <= 32'd0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         resp_valid_q <= resp_valid_d;
         resp_pc_q    <= resp_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_pc_q    <= hold_pc_d;
         hold_inst_q  <= hold_inst_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized
// ready/redirect run checked against a transfer-level stream model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 0: RESET_PC = 0
   logic        rst, redirect_valid, out_ready, out_valid;
   logic [31:0] imem_addr, imem_inst, redirect_pc, out_pc, out_inst;
   // DUT 1: RESET_PC near the top of the address space
   logic        rst1, redirect_valid1, out_ready1, out_valid1;
   logic [31:0] imem_addr1, imem_inst1, redirect_pc1, out_pc1, out_inst1;

   int checks = 0;
   int failures = 0;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst));

   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .rst(rst1), .imem_addr(imem_addr1), .imem_inst(imem_inst1),
      .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_pc(out_pc1), .out_inst(out_inst1));

   // Memory contents: word i holds A000_0000 + i, indexed by addr[8:2].
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 + {25'd0, a[8:2]};
   endfunction

   // Synchronous memories, one-cycle read latency.
   always @(posedge clk) begin
      imem_inst  <= mem_word(imem_addr);
      imem_inst1 <= mem_word(imem_addr1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".pc"}, out_pc, pc);
      chk({tag, ".inst"}, out_inst, mem_word(pc));
   endtask

   // Bounded wait for out_valid on DUT 0.
   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 4) begin
         cyc();
         n++;
      end
      chk({tag, ".wait"}, {31'd0, out_valid}, 32'd1);
   endtask

   // Random-phase model state
   logic [31:0] exp_pc, prev_pc, prev_inst, prev_tgt;
   logic        prev_stall, prev_redir, prev_idle;

   initial begin
      rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
      rst1 = 1'b1; out_ready1 = 1'b1; redirect_valid1 = 1'b0; redirect_pc1 = 32'd0;
      #2;
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.addr", imem_addr, 32'd0);
      chk("rst1.addr", imem_addr1, 32'hFFFF_FFF8);
      cyc();
      rst = 1'b0;
      #1;
      chk("rel.valid", {31'd0, out_valid}, 32'd0);

      // Streaming after reset: one word per cycle from RESET_PC.
      cyc(); chk_out("s0", 32'h0);
      cyc(); chk_out("s1", 32'h4);
      cyc(); chk_out("s2", 32'h8);

      // Three stall cycles at pc 8: word must stay put.
      out_ready = 1'b0; #1; chk_out("st0", 32'h8);
      cyc(); chk_out("st1", 32'h8);
      cyc(); chk_out("st2", 32'h8);
      out_ready = 1'b1; #1; chk_out("st.xfer", 32'h8);
      cyc(); wait_valid("st.w12"); chk_out("st.12", 32'hC);
      cyc(); chk_out("st.16", 32'h10);
      cyc(); chk_out("st.20", 32'h14);

      // Redirect while streaming.
      redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      chk("rd.valid", {31'd0, out_valid}, 32'd0);
      chk("rd.addr", imem_addr, 32'h40);
      cyc(); redirect_valid = 1'b0; #1; chk_out("rd.40", 32'h40);
      cyc(); chk_out("rd.44", 32'h44);
      cyc(); chk_out("rd.48", 32'h48);

      // Redirect while the stalled word sits in hold.
      out_ready = 1'b0; #1; chk_out("rh.48a", 32'h48);
      cyc(); chk_out("rh.48b", 32'h48);
      redirect_valid = 1'b1; redirect_pc = 32'h23; #1;
      chk("rh.valid", {31'd0, out_valid}, 32'd0);
      chk("rh.addr", imem_addr, 32'h20);
      cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #1; chk_out("rh.20", 32'h20);
      cyc(); chk_out("rh.24", 32'h24);

      // Asynchronous reset during a stall.
      out_ready = 1'b0; #1;
      cyc(); chk_out("ar.hold", 32'h24);
      rst = 1'b1; #1;
      chk("ar.valid", {31'd0, out_valid}, 32'd0);
      chk("ar.addr", imem_addr, 32'd0);
      cyc(); cyc();
      rst = 1'b0; out_ready = 1'b1; #1;
      chk("ar.rel", {31'd0, out_valid}, 32'd0);
      cyc(); chk_out("ar.0", 32'h0);
      cyc(); chk_out("ar.4", 32'h4);

      // Address wrap from the second instance.
      rst1 = 1'b0; #1;
      chk("w.rel", {31'd0, out_valid1}, 32'd0);
      cyc();
      chk("w0.pc", out_pc1, 32'hFFFF_FFF8); chk("w0.inst", out_inst1, mem_word(32'hFFFF_FFF8));
      chk("w0.valid", {31'd0, out_valid1}, 32'd1);
      cyc(); chk("w1.pc", out_pc1, 32'hFFFF_FFFC); chk("w1.valid", {31'd0, out_valid1}, 32'd1);
      cyc(); chk("w2.pc", out_pc1, 32'h0000_0000); chk("w2.inst", out_inst1, mem_word(32'h0));
      cyc(); chk("w3.pc", out_pc1, 32'h0000_0004); chk("w3.valid", {31'd0, out_valid1}, 32'd1);

      // Random ready/redirect run. Model: the accepted stream is consecutive
      // words from the latest redirect target; a redirect cycle offers nothing
      // and the next cycle offers the target; a refused word is re-offered
      // unchanged; no two consecutive empty cycles without a redirect.
      exp_pc = 32'd0; prev_pc = 32'd0; prev_inst = 32'd0; prev_tgt = 32'd0;
      prev_stall = 1'b0; prev_redir = 1'b0; prev_idle = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         logic        rd, rdy;
         rd  = (i == 0) || ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         tgt = $urandom;
         redirect_valid = rd; redirect_pc = tgt; out_ready = rdy;
         #1;
         if (rd) begin
            chk("r.rdvalid", {31'd0, out_valid}, 32'd0);
            exp_pc = {tgt[31:2], 2'b00};
         end else begin
            if (prev_redir) begin
               chk("r.tgtvalid", {31'd0, out_valid}, 32'd1);
               chk("r.tgtpc", out_pc, prev_tgt);
            end
            if (prev_stall) begin
               chk("r.stallvalid", {31'd0, out_valid}, 32'd1);
               chk("r.stallpc", out_pc, prev_pc);
               chk("r.stallinst", out_inst, prev_inst);
            end
            if (prev_idle) chk("r.bubble", {31'd0, out_valid}, 32'd1);
            if (out_valid) begin
               chk("r.inst", out_inst, mem_word(out_pc));
               if (rdy) begin
                  chk("r.order", out_pc, exp_pc);
                  exp_pc = out_pc + 32'd4;
               end
            end
         end
         prev_redir = rd;
         prev_tgt   = {tgt[31:2], 2'b00};
         prev_stall = !rd && out_valid && !rdy;
         prev_pc    = out_pc;
         prev_inst  = out_inst;
         prev_idle  = !rd && !out_valid;
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
